fstore_blit: RTL

- Word-granular copy/fill engine for the text/graphics framebuffer RAM.
- Sits between the CPU HID bus and the framebuffer's 64-bit CPU-side port, and shares that single port between CPU accesses and engine accesses.
- Typical uses: hardware scroll (copy rows up) and clear-screen (fill).
- The CPU always has priority. The engine uses only the cycles in which the CPU is not accessing the framebuffer.

---
 rtl/fstore_pkg.sv | 32 +++
 rtl/fstore_port_arb.sv | 41 ++++
 rtl/fstore_blit.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fstore_pkg.sv
// Shared constants and types for the framebuffer copy/fill engine.
package fstore_pkg;

    localparam logic [2:0] REG_SRC   = 3'd0;
    localparam logic [2:0] REG_DST   = 3'd1;
    localparam logic [2:0] REG_COUNT = 3'd2;
    localparam logic [2:0] REG_FILL  = 3'd3;
    localparam logic [2:0] REG_CTRL  = 3'd4;

    // CTRL write bits
    localparam int CTRL_START = 0;
    localparam int CTRL_MODE  = 1;
    localparam int CTRL_ABORT = 2;
    localparam int CTRL_IEN   = 3;
    localparam int CTRL_CLEAR = 4;

    // CTRL read bits
    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ABORTED = 2;
    localparam int STAT_IEN     = 3;
    localparam int STAT_REM_LSB = 16;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RWAIT,
        WR,
        FILL
    } blit_state_t;

endpackage

// File: rtl/fstore_port_arb.sv
// Combinational owner select for the framebuffer port: a CPU framebuffer
// access always wins, otherwise the engine request drives the port.
module fstore_port_arb #(
    parameter int FB_BIT = 19
) (
    input  logic        i_cpu_en,
    input  logic        i_cpu_sel,
    input  logic [7:0]  i_cpu_we,
    input  logic [19:0] i_cpu_addr,
    input  logic [63:0] i_cpu_wrdata,
    input  logic        i_eng_req,
    input  logic [7:0]  i_eng_we,
    input  logic [19:0] i_eng_addr,
    input  logic [63:0] i_eng_wrdata,
    output logic        o_eng_gnt,
    output logic        o_mem_en,
    output logic [7:0]  o_mem_we,
    output logic [19:0] o_mem_addr,
    output logic [63:0] o_mem_wrdata
);

    logic w_cpu_fb;

    assign w_cpu_fb  = i_cpu_en & ~i_cpu_sel & i_cpu_addr[FB_BIT];
    assign o_eng_gnt = ~w_cpu_fb;

    always_comb begin
        if (w_cpu_fb) begin
            o_mem_en     = 1'b1;
            o_mem_we     = i_cpu_we;
            o_mem_addr   = i_cpu_addr;
            o_mem_wrdata = i_cpu_wrdata;
        end else begin
            o_mem_en     = i_eng_req;
            o_mem_we     = i_eng_req ? i_eng_we : 8'h00;
            o_mem_addr   = i_eng_addr;
            o_mem_wrdata = i_eng_wrdata;
        end
    end

endmodule

// File: rtl/fstore_blit.sv
// Word-granular copy/fill engine sharing the framebuffer CPU-side port.
// The engine only issues accesses in cycles the CPU leaves the port idle.
module fstore_blit
    import fstore_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int FB_BIT = 19
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cpu_en,
    input  logic [7:0]  cpu_we,
    input  logic [19:0] cpu_addr,
    input  logic [63:0] cpu_wrdata,
    input  logic        cpu_sel,
    output logic [63:0] cpu_rddata,
    output logic        mem_en,
    output logic [7:0]  mem_we,
    output logic [19:0] mem_addr,
    output logic [63:0] mem_wrdata,
    input  logic [63:0] mem_rddata,
    output logic        irq_o
);

    blit_state_t      r_state;
    logic [CNT_W-1:0] r_src, r_dst, r_count;
    logic [CNT_W-1:0] r_wsrc, r_wdst, r_rem;
    logic [63:0]      r_fill, r_buf, r_reg_rd;
    logic             r_ien, r_done, r_aborted, r_rd_mem;

    logic             w_busy, w_reg_wr, w_reg_rd, w_ctrl_wr, w_abort, w_start;
    logic             w_gnt, w_eng_req, w_eng_fire;
    logic [2:0]       w_idx;
    logic [7:0]       w_eng_we;
    logic [CNT_W-1:0] w_eng_word;
    logic [19:0]      w_eng_addr;
    logic [63:0]      w_eng_data, w_reg_val;

    assign w_idx     = cpu_addr[5:3];
    assign w_busy    = (r_state != IDLE);
    assign w_reg_wr  = cpu_en & cpu_sel & (|cpu_we);
    assign w_reg_rd  = cpu_en & cpu_sel & ~(|cpu_we);
    assign w_ctrl_wr = w_reg_wr & (w_idx == REG_CTRL);
    assign w_abort   = w_ctrl_wr & cpu_wrdata[CTRL_ABORT];
    assign w_start   = w_ctrl_wr & cpu_wrdata[CTRL_START] & ~cpu_wrdata[CTRL_ABORT] & ~w_busy;

    always_comb begin
        w_eng_req  = 1'b0;
        w_eng_we   = 8'h00;
        w_eng_word = r_wdst;
        w_eng_data = r_fill;
        unique case (r_state)
            RD: begin
                w_eng_req  = 1'b1;
                w_eng_word = r_wsrc;
            end
            WR: begin
                w_eng_req  = 1'b1;
                w_eng_we   = 8'hFF;
                w_eng_data = r_buf;
            end
            FILL: begin
                w_eng_req  = 1'b1;
                w_eng_we   = 8'hFF;
            end
            default: ;
        endcase
        // An abort arriving this cycle kills the request so a pending write never reaches the port.
        if (w_abort) begin
            w_eng_req = 1'b0;
            w_eng_we  = 8'h00;
        end
    end

    assign w_eng_addr = {1'b1, w_eng_word, 3'b000};
    assign w_eng_fire = w_eng_req & w_gnt;

    fstore_port_arb #(
        .FB_BIT (FB_BIT)
    ) u_arb (
        .i_cpu_en     (cpu_en),
        .i_cpu_sel    (cpu_sel),
        .i_cpu_we     (cpu_we),
        .i_cpu_addr   (cpu_addr),
        .i_cpu_wrdata (cpu_wrdata),
        .i_eng_req    (w_eng_req),
        .i_eng_we     (w_eng_we),
        .i_eng_addr   (w_eng_addr),
        .i_eng_wrdata (w_eng_data),
        .o_eng_gnt    (w_gnt),
        .o_mem_en     (mem_en),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wrdata (mem_wrdata)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_wsrc    <= '0;
            r_wdst    <= '0;
            r_rem     <= '0;
            r_buf     <= '0;
            r_ien     <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_ien <= cpu_wrdata[CTRL_IEN];
                if (cpu_wrdata[CTRL_CLEAR]) begin
                    r_done    <= 1'b0;
                    r_aborted <= 1'b0;
                end
            end
            unique case (r_state)
                IDLE: begin
                    if (w_start) begin
                        if (r_count == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_done    <= 1'b0;
                            r_aborted <= 1'b0;
                            r_wsrc    <= r_src;
                            r_wdst    <= r_dst;
                            r_rem     <= r_count;
                            r_state   <= cpu_wrdata[CTRL_MODE] ? FILL : RD;
                        end
                    end
                end
                RD: begin
                    if (w_eng_fire) r_state <= RWAIT;
                end
                RWAIT: begin
                    r_buf   <= mem_rddata;
                    r_state <= WR;
                end
                WR, FILL: begin
                    if (w_eng_fire) begin
                        r_wdst <= r_wdst + 1'b1;
                        r_rem  <= r_rem - 1'b1;
                        if (r_state == WR) r_wsrc <= r_wsrc + 1'b1;
                        if (r_rem == CNT_W'(1)) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end else if (r_state == WR) begin
                            r_state <= RD;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
            // NOTE: non-blocking assignments resolve last-wins, so this abort overrides any transition above.
            if (w_abort && w_busy) begin
                r_state   <= IDLE;
                r_aborted <= 1'b1;
            end
        end
    end

    always_comb begin
        w_reg_val = '0;
        case (w_idx)
            REG_SRC:   w_reg_val[CNT_W-1:0] = r_src;
            REG_DST:   w_reg_val[CNT_W-1:0] = r_dst;
            REG_COUNT: w_reg_val[CNT_W-1:0] = r_count;
            REG_FILL:  w_reg_val            = r_fill;
            REG_CTRL: begin
                w_reg_val[STAT_BUSY]                = w_busy;
                w_reg_val[STAT_DONE]                = r_done;
                w_reg_val[STAT_ABORTED]             = r_aborted;
                w_reg_val[STAT_IEN]                 = r_ien;
                w_reg_val[STAT_REM_LSB +: CNT_W]    = r_rem;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_src    <= '0;
            r_dst    <= '0;
            r_count  <= '0;
            r_fill   <= '0;
            r_reg_rd <= '0;
            r_rd_mem <= 1'b0;
        end else begin
            if (w_reg_wr && !w_busy) begin
                case (w_idx)
                    REG_SRC:   r_src   <= cpu_wrdata[CNT_W-1:0];
                    REG_DST:   r_dst   <= cpu_wrdata[CNT_W-1:0];
                    REG_COUNT: r_count <= cpu_wrdata[CNT_W-1:0];
                    REG_FILL:  r_fill  <= cpu_wrdata;
                    default: ;
                endcase
            end
            if (w_reg_rd) r_reg_rd <= w_reg_val;
            r_rd_mem <= cpu_en & ~cpu_sel;
        end
    end

    assign cpu_rddata = r_rd_mem ? mem_rddata : r_reg_rd;
    assign irq_o      = r_done & r_ien;

endmodule
